// File: rtl/fifo_sync_param.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_sync_param
//  Purpose  : Single-clock parameterised FIFO with registered read data,
//             occupancy count, full/empty/almost flags and optional sticky
//             overflow/underflow error flags.
//  Macro    : FIFO_SYNC_PARAM_ERR_FLAGS_EN - when defined, overflow/underflow
//             are live sticky flags cleared by rst or err_clr; when undefined
//             they read as 0 and err_clr is ignored.
//  Ports    : clk, rst (sync, active-high)
//             write_en, data_in        - write request and data
//             read_en, data_out        - read request, registered read data
//             full, empty, almost_full, almost_empty, count - status
//             err_clr, overflow, underflow                  - error flags
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_sync_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       write_en,
  input  logic                       read_en,
  input  logic [WIDTH-1:0]           data_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  input  logic                       err_clr,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned c_CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_CW-1:0]  r_count;
  logic [WIDTH-1:0] r_data_out;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  assign w_full  = (r_count == c_CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // A write into a full FIFO is still accepted when a read frees the oldest
  // slot in the same cycle; a read of an empty FIFO is never accepted.
  assign w_wr_acc = write_en & (~w_full | read_en);
  assign w_rd_acc = read_en & ~w_empty;

  // Storage carries no reset: stale words can never reach data_out because
  // reads are gated by the (reset) count.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_acc) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_data_out <= '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow wraps correctly.
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr   <= r_rd_ptr + c_AW'(1);
        // On full+write+read the pointers coincide; the non-blocking memory
        // write guarantees the old word is the one captured here.
        r_data_out <= r_mem[r_rd_ptr];
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign data_out     = r_data_out;
  assign count        = r_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= c_CW'(AF_LEVEL));
  assign almost_empty = (r_count <= c_CW'(AE_LEVEL));

`ifdef FIFO_SYNC_PARAM_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  // A new error in the same cycle as err_clr wins, so the flag stays set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (write_en & ~w_wr_acc) | (r_overflow  & ~err_clr);
      r_underflow <= (read_en  &  w_empty)  | (r_underflow & ~err_clr);
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = err_clr;
  assign overflow         = 1'b0;
  assign underflow        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_sync_param
//  Purpose  : Self-checking bench for fifo_sync_param (WIDTH=8, DEPTH=4,
//             AF_LEVEL=3, AE_LEVEL=1). A queue-based reference model predicts
//             every output after each clock; directed scenarios are followed
//             by randomized traffic. Honors FIFO_SYNC_PARAM_ERR_FLAGS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_sync_param;

  localparam int c_DEPTH = 4;
`ifdef FIFO_SYNC_PARAM_ERR_FLAGS_EN
  localparam bit c_ERR_ON = 1'b1;
`else
  localparam bit c_ERR_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, write_en, read_en, err_clr;
  logic [7:0] data_in, data_out;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [2:0] count;

  fifo_sync_param #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) u_dut (
    .clk(clk), .rst(rst), .write_en(write_en), .read_en(read_en),
    .data_in(data_in), .data_out(data_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .err_clr(err_clr), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] m_q[$];
  logic [7:0] m_dout;
  bit         m_ov, m_un;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clock(input bit we, input bit re, input logic [7:0] d,
                             input bit clr, input bit rs);
    bit is_full, is_empty, wacc, racc;
    if (rs) begin
      m_q.delete();
      m_dout = 8'h00;
      m_ov   = 1'b0;
      m_un   = 1'b0;
    end else begin
      is_full  = (m_q.size() == c_DEPTH);
      is_empty = (m_q.size() == 0);
      wacc     = we && (!is_full || re);
      racc     = re && !is_empty;
      if (racc) m_dout = m_q.pop_front();
      if (wacc) m_q.push_back(d);
      m_ov = c_ERR_ON && ((we && !wacc) || (m_ov && !clr));
      m_un = c_ERR_ON && ((re && is_empty) || (m_un && !clr));
    end
  endtask

  task automatic check_all();
    chk("count",        32'(count),        32'(m_q.size()));
    chk("full",         32'(full),         32'(m_q.size() == c_DEPTH));
    chk("empty",        32'(empty),        32'(m_q.size() == 0));
    chk("almost_full",  32'(almost_full),  32'(m_q.size() >= 3));
    chk("almost_empty", 32'(almost_empty), 32'(m_q.size() <= 1));
    chk("data_out",     32'(data_out),     32'(m_dout));
    chk("overflow",     32'(overflow),     32'(m_ov));
    chk("underflow",    32'(underflow),    32'(m_un));
  endtask

  // One clock: drive inputs away from the edge, advance model, then check.
  task automatic step(input bit we, input bit re, input logic [7:0] d,
                      input bit clr = 1'b0, input bit rs = 1'b0);
    write_en = we;
    read_en  = re;
    data_in  = d;
    err_clr  = clr;
    rst      = rs;
    @(posedge clk);
    model_clock(we, re, d, clr, rs);
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; write_en = 1'b0; read_en = 1'b0; data_in = 8'h00; err_clr = 1'b0;
    m_dout = 8'h00; m_ov = 1'b0; m_un = 1'b0;
    #2;

    // Reset state
    step(0, 0, 8'h00, 0, 1);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_dout",  32'(data_out), 32'h00);

    // Basic FIFO order
    step(1, 0, 8'h11); step(1, 0, 8'h22); step(1, 0, 8'h33); step(1, 0, 8'h44);
    chk("fill_full", 32'(full), 32'd1);
    step(0, 1, 8'h00); chk("rd1", 32'(data_out), 32'h11);
    step(0, 1, 8'h00); chk("rd2", 32'(data_out), 32'h22);
    step(0, 1, 8'h00); chk("rd3", 32'(data_out), 32'h33);
    step(0, 1, 8'h00); chk("rd4", 32'(data_out), 32'h44);
    chk("drain_empty", 32'(empty), 32'd1);

    // Overflow: write to full without read is dropped
    step(1, 0, 8'hA1); step(1, 0, 8'hA2); step(1, 0, 8'hA3); step(1, 0, 8'hA4);
    step(1, 0, 8'h55);
    chk("ovf_count", 32'(count), 32'd4);
    chk("ovf_flag",  32'(overflow), 32'(c_ERR_ON));
    step(0, 1, 8'h00); chk("ovf_oldest", 32'(data_out), 32'hA1);

    // Full with simultaneous write and read
    step(1, 0, 8'hA5);
    step(1, 1, 8'h66);
    chk("fwr_dout",  32'(data_out), 32'hA2);
    chk("fwr_count", 32'(count), 32'd4);
    step(0, 1, 8'h00); step(0, 1, 8'h00); step(0, 1, 8'h00);
    chk("fwr_before", 32'(data_out), 32'hA5);
    step(0, 1, 8'h00); chk("fwr_last", 32'(data_out), 32'h66);

    // Underflow on empty read, then clear (overflow may clear too)
    step(0, 1, 8'h00);
    chk("unf_dout", 32'(data_out), 32'h66);
    chk("unf_flag", 32'(underflow), 32'(c_ERR_ON));
    step(0, 0, 8'h00, 1);
    chk("unf_clr", 32'(underflow), 32'd0);

    // Empty with write and read: write only
    step(1, 1, 8'h5A);
    chk("ewr_count", 32'(count), 32'd1);
    chk("ewr_dout",  32'(data_out), 32'h66);
    // Error clear colliding with a new error keeps flag set
    step(0, 1, 8'h00); step(0, 1, 8'h00, 1);
    chk("clr_vs_new", 32'(underflow), 32'(c_ERR_ON));
    step(0, 0, 8'h00, 1);

    // Ten write/read cycles through pointer wrap-around
    for (int i = 0; i < 10; i++) begin
      step(1, (i % 3) != 0, 8'(8'hC0 + i));
    end
    while (m_q.size() != 0) step(0, 1, 8'h00);

    // Mid-operation reset
    step(1, 0, 8'h01); step(1, 0, 8'h02); step(1, 0, 8'h03);
    step(1, 1, 8'hEE, 0, 1);
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_empty", 32'(empty), 32'd1);
    chk("mrst_dout",  32'(data_out), 32'h00);
    step(1, 0, 8'h77); step(0, 1, 8'h00);
    chk("mrst_first", 32'(data_out), 32'h77);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      step(bit'($urandom_range(0, 99) < 55), bit'($urandom_range(0, 99) < 50),
           8'($urandom), bit'($urandom_range(0, 15) == 0),
           bit'($urandom_range(0, 63) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_sync_param.md
FIFO_SYNC_PARAM -- requirements
Module: fifo_sync_param

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 4, number of entries (power of two, >=2).
REQ-003 Parameter AF_LEVEL, default DEPTH-1, almost_full threshold (1..DEPTH).
REQ-004 Parameter AE_LEVEL, default 1, almost_empty threshold (0..DEPTH-1).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 write_en  input  1  write request.
REQ-008 read_en  input  1  read request.
REQ-009 data_in  input  WIDTH  write data.
REQ-010 data_out  output  WIDTH  registered read data.
REQ-011 full  output  1  high when count == DEPTH.
REQ-012 empty  output  1  high when count == 0.
REQ-013 almost_full  output  1  high when count >= AF_LEVEL.
REQ-014 almost_empty  output  1  high when count <= AE_LEVEL.
REQ-015 count  output  $clog2(DEPTH+1)  current occupancy.
REQ-016 err_clr  input  1  clears sticky error flags.
REQ-017 overflow  output  1  sticky: write request rejected.
REQ-018 underflow  output  1  sticky: read request rejected.

Function
REQ-019 wr_acc = write_en & (!full | read_en); rd_acc = read_en & !empty.
REQ-020 Full + write_en + read_en: both accepted; the oldest word is read, the new word is written to the freed slot; count stays DEPTH.
REQ-021 Empty + write_en + read_en: write accepted, read rejected; count becomes 1; data_out holds.
REQ-022 On rd_acc, data_out loads mem[rd_ptr] at that edge (1-cycle read latency); otherwise data_out holds its value.
REQ-023 On wr_acc, mem[wr_ptr] <= data_in; wr_ptr advances modulo DEPTH. On rd_acc, rd_ptr advances modulo DEPTH.
REQ-024 count: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither occur; count never exceeds DEPTH and never goes below 0.
REQ-025 full, empty, almost_full and almost_empty are combinational decodes of registered count.
REQ-026 Ordering is strictly first-in-first-out across pointer wrap-around.
REQ-027 Rejected requests change no pointer, count, memory word or data_out.

Reset
REQ-028 rst high at a clock edge: wr_ptr=0, rd_ptr=0, count=0, data_out=0, overflow=0, underflow=0; rst takes priority over all concurrent requests.
REQ-029 After reset: empty=1, full=0, almost_empty=1, almost_full=0 (for AF_LEVEL>0); memory contents are don't-care and are never visible on data_out until written.
REQ-030 Reset asserted mid-operation discards all stored words; the first read after reset returns the first word written after reset.

Configuration
REQ-031 Macro FIFO_SYNC_PARAM_ERR_FLAGS_EN defined: overflow is set when write_en & !wr_acc, underflow is set when read_en & empty; both are sticky until rst or err_clr; err_clr and a new error in the same cycle leave the flag set.
REQ-032 Macro FIFO_SYNC_PARAM_ERR_FLAGS_EN undefined: overflow and underflow are tied to 0 and err_clr is ignored; all ports remain present.

Verification (WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1)
REQ-033 Write 0x11,0x22,0x33,0x44, then 4 reads -> data_out 0x11,0x22,0x33,0x44, each one cycle after its read; full=1 after the 4th write; empty=1 after the 4th read.
REQ-034 Fill to full, then write 0x55 without read -> word dropped, count=4, overflow=1 (macro on) or 0 (macro off); the next read returns the oldest word.
REQ-035 Full, write 0x66 with read -> returns the oldest word, count stays 4; 0x66 is read last after 3 further reads.
REQ-036 Empty, read only -> data_out unchanged, underflow=1 (macro on); then err_clr -> underflow=0.
REQ-037 Run 10 write/read cycles with pointer wrap, checking almost_full at count 3 and almost_empty at count<=1 -> order preserved, flags match count.
REQ-038 Hold count=3 and assert rst -> next cycle count=0, empty=1, data_out=0; write 0x77 then read -> data_out=0x77.
